// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Resolves three event sources with a fixed priority:
//   memory stall > taken branch > load-use hazard.
// A memory stall freezes the whole front end and bubbles MEM/WB. A taken
// branch flushes IF/ID and ID/EX, then keeps flushing IF/ID for FLUSH_CYCLES.
// A load-use hazard holds PC and IF/ID for one cycle and injects a bubble
// into ID/EX.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   id_rs1_sel/rs2_sel  ID-stage source registers
//   id_uses_rs1/rs2     ID instruction actually reads the source
//   ex_rd_sel           EX-stage destination register
//   ex_ctrl_mem_read    EX instruction is a load
//   ex_branch_taken     EX resolved a taken branch/jump
//   mem_req, mem_ready  data memory handshake
//   pc_en .. mem_wb_bubble  pipeline register enables / flushes (combinational)
//   state               FSM state (RUN=0, FLUSH=1, MEM_WAIT=2)
//   stall_cycles        saturating count of cycles with pc_en=0
//   err_timeout         sticky flag: MEM_WAIT lasted MEM_TIMEOUT cycles
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,   // 0..15
  parameter int unsigned MEM_TIMEOUT  = 255  // 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_sel,
  input  logic [4:0]  id_rs2_sel,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_sel,
  input  logic        ex_ctrl_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_bubble,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic        err_timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam logic [3:0]  FC = 4'(FLUSH_CYCLES);
  localparam logic [15:0] MT = 16'(MEM_TIMEOUT);

  state_t      st;
  logic [3:0]  flush_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        mem_stall;
  logic        lu_haz;
  ctrl_t       ctl;

  assign mem_stall = mem_req && !mem_ready;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign lu_haz = ex_ctrl_mem_read && (ex_rd_sel != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1_sel == ex_rd_sel)) ||
                   (id_uses_rs2 && (id_rs2_sel == ex_rd_sel)));

  // Saturate so a very long wait can never wrap back under the threshold.
  assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  // Outputs depend only on state and inputs. MEM_WAIT needs no special case:
  // once mem_ready rises mem_stall drops and the RUN rules apply directly.
  always_comb begin
    ctl = '0;
    if (rst) begin
      if (mem_stall) begin
        // Freeze everything; EX is frozen too, so a pending branch re-presents
        // after the stall. FLUSH keeps its IF/ID flush asserted while frozen.
        ctl.mem_wb_bubble = 1'b1;
        ctl.if_id_flush   = (st == FLUSH);
      end else if (ex_branch_taken) begin
        ctl = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
                id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_bubble: 1'b0};
      end else if (lu_haz) begin
        ctl.id_ex_en    = 1'b1;
        ctl.id_ex_flush = 1'b1;
        ctl.ex_mem_en   = 1'b1;
        ctl.if_id_flush = (st == FLUSH);
      end else begin
        ctl.pc_en       = 1'b1;
        ctl.if_id_en    = 1'b1;
        ctl.id_ex_en    = 1'b1;
        ctl.ex_mem_en   = 1'b1;
        ctl.if_id_flush = (st == FLUSH);
      end
    end
  end

  assign pc_en         = ctl.pc_en;
  assign if_id_en      = ctl.if_id_en;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_en      = ctl.id_ex_en;
  assign id_ex_flush   = ctl.id_ex_flush;
  assign ex_mem_en     = ctl.ex_mem_en;
  assign mem_wb_bubble = ctl.mem_wb_bubble;
  assign state         = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= RUN;
      flush_cnt    <= '0;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if (!ctl.pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;

      case (st)
        RUN, MEM_WAIT: begin
          if (mem_stall) begin
            st <= MEM_WAIT;
            // Only cycles actually spent in MEM_WAIT count toward the timeout.
            if (st == MEM_WAIT) begin
              wait_cnt <= wait_inc;
              if (wait_inc >= MT) err_timeout <= 1'b1;
            end
          end else begin
            wait_cnt <= '0;
            if (ex_branch_taken && (FC != 4'd0)) begin
              st        <= FLUSH;
              flush_cnt <= FC;
            end else begin
              st <= RUN;
            end
          end
        end
        FLUSH: begin
          if (mem_stall) begin
            // frozen: hold state and counter
          end else if (ex_branch_taken) begin
            flush_cnt <= FC;
          end else if (flush_cnt < 4'd2) begin
            flush_cnt <= '0;
            st        <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (FLUSH_CYCLES=1, MEM_TIMEOUT=4).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1_sel, id_rs2_sel, ex_rd_sel;
  logic        id_uses_rs1, id_uses_rs2, ex_ctrl_mem_read, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic        mem_wb_bubble, err_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  logic [6:0]  ctl;

  int n_tot = 0;
  int n_bad = 0;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}
  localparam logic [6:0] C_RST = 7'b0000000;
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_FFZ = 7'b0010001;  // frozen inside FLUSH
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_FL  = 7'b1111010;

  localparam logic [31:0] S_RUN = 32'd0, S_FLUSH = 32'd1, S_WAIT = 32'd2;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_sel(id_rs1_sel), .id_rs2_sel(id_rs2_sel),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_sel(ex_rd_sel), .ex_ctrl_mem_read(ex_ctrl_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble), .state(state),
    .stall_cycles(stall_cycles), .err_timeout(err_timeout)
  );

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    id_rs1_sel = 5'd0; id_rs2_sel = 5'd0; ex_rd_sel = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_ctrl_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic lu_in;
    ex_ctrl_mem_read = 1'b1; ex_rd_sel = 5'd5; id_rs1_sel = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    clr_in();
    #3;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_state", 32'(state), S_RUN);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    #4 rst = 1'b1;
    cyc();
    #1 chk("idle_ctl", 32'(ctl), 32'(C_RUN));

    // load-use on rs1: one stall cycle
    cyc(); lu_in();
    #1 chk("lu1_ctl", 32'(ctl), 32'(C_LU));
    cyc(); clr_in();
    #1 chk("lu1_after", 32'(ctl), 32'(C_RUN));
    chk("lu1_stall", stall_cycles, 32'd1);
    chk("lu1_state", 32'(state), S_RUN);

    // load-use on rs2
    ex_ctrl_mem_read = 1'b1; ex_rd_sel = 5'd7; id_rs2_sel = 5'd7; id_uses_rs2 = 1'b1;
    #1 chk("lu2_ctl", 32'(ctl), 32'(C_LU));
    cyc(); id_uses_rs2 = 1'b0;  // same regs, but rs2 not read
    #1 chk("lu2_unused", 32'(ctl), 32'(C_RUN));
    chk("lu2_stall", stall_cycles, 32'd2);

    // load to x0 never stalls
    clr_in(); ex_ctrl_mem_read = 1'b1; id_uses_rs1 = 1'b1;
    #1 chk("x0_ctl", 32'(ctl), 32'(C_RUN));
    cyc(); clr_in();
    #1 chk("x0_stall", stall_cycles, 32'd2);

    // taken branch: flush both, then one FLUSH cycle, then RUN
    ex_branch_taken = 1'b1;
    #1 chk("br0_ctl", 32'(ctl), 32'(C_BR));
    cyc(); ex_branch_taken = 1'b0;
    #1 chk("br1_state", 32'(state), S_FLUSH);
    chk("br1_ctl", 32'(ctl), 32'(C_FL));
    cyc();
    #1 chk("br2_state", 32'(state), S_RUN);
    chk("br2_ctl", 32'(ctl), 32'(C_RUN));

    // second branch inside FLUSH restarts the counter
    ex_branch_taken = 1'b1;
    cyc();
    #1 chk("rs_ctl", 32'(ctl), 32'(C_BR));
    cyc(); ex_branch_taken = 1'b0;
    #1 chk("rs_state", 32'(state), S_FLUSH);
    cyc();
    #1 chk("rs_end", 32'(state), S_RUN);

    // memory stall inside FLUSH: freeze, hold counter, keep IF/ID flush
    ex_branch_taken = 1'b1;
    cyc(); ex_branch_taken = 1'b0; mem_req = 1'b1;
    #1 chk("ffz_ctl", 32'(ctl), 32'(C_FFZ));
    cyc();
    #1 chk("ffz_state", 32'(state), S_FLUSH);
    cyc(); mem_ready = 1'b1;
    #1 chk("ffz_rel", 32'(ctl), 32'(C_FL));
    cyc(); clr_in();
    #1 chk("ffz_end", 32'(state), S_RUN);
    chk("ffz_stall", stall_cycles, 32'd4);

    // plain memory stall of three cycles
    mem_req = 1'b1;
    #1 chk("ms0_ctl", 32'(ctl), 32'(C_FRZ));
    cyc();
    #1 chk("ms1_state", 32'(state), S_WAIT);
    chk("ms1_ctl", 32'(ctl), 32'(C_FRZ));
    cyc();
    #1 chk("ms2_ctl", 32'(ctl), 32'(C_FRZ));
    cyc(); mem_ready = 1'b1;
    #1 chk("ms3_ctl", 32'(ctl), 32'(C_RUN));
    cyc(); clr_in();
    #1 chk("ms4_state", 32'(state), S_RUN);
    chk("ms_stall", stall_cycles, 32'd7);

    // stall + branch + load-use together: freeze only, then branch flush
    mem_req = 1'b1; ex_branch_taken = 1'b1; lu_in();
    #1 chk("sim0_ctl", 32'(ctl), 32'(C_FRZ));
    cyc();
    #1 chk("sim1_state", 32'(state), S_WAIT);
    cyc(); mem_ready = 1'b1;
    #1 chk("sim2_ctl", 32'(ctl), 32'(C_BR));
    cyc(); clr_in();
    #1 chk("sim3_state", 32'(state), S_FLUSH);
    cyc();
    #1 chk("sim_stall", stall_cycles, 32'd9);

    // mem_ready cycle honours a load-use hazard immediately
    mem_req = 1'b1;
    cyc(); mem_ready = 1'b1; lu_in();
    #1 chk("rl_ctl", 32'(ctl), 32'(C_LU));
    cyc(); clr_in();
    #1 chk("rl_state", 32'(state), S_RUN);
    chk("rl_stall", stall_cycles, 32'd11);

    // timeout: four MEM_WAIT cycles raise err_timeout, waiting continues
    mem_req = 1'b1;
    repeat (4) cyc();
    #1 chk("to_s5_err", 32'(err_timeout), 32'd0);
    cyc();
    #1 chk("to_s6_err", 32'(err_timeout), 32'd1);
    cyc();
    #1 chk("to_s7_state", 32'(state), S_WAIT);
    chk("to_s7_stall", stall_cycles, 32'd17);
    rst = 1'b0;
    #1 chk("to_rst_err", 32'(err_timeout), 32'd0);
    chk("to_rst_state", 32'(state), S_RUN);
    chk("to_rst_stall", stall_cycles, 32'd0);
    chk("to_rst_ctl", 32'(ctl), 32'(C_RST));
    clr_in();
    #2 rst = 1'b1;
    cyc();
    #1 chk("to_post", 32'(state), S_RUN);
    chk("to_post_ctl", 32'(ctl), 32'(C_RUN));

    // reset in the middle of FLUSH
    ex_branch_taken = 1'b1;
    cyc(); ex_branch_taken = 1'b0;
    #1 chk("fr_state", 32'(state), S_FLUSH);
    rst = 1'b0;
    #1 chk("fr_rst", 32'(state), S_RUN);
    #2 rst = 1'b1;
    cyc();
    #1 chk("fr_post", 32'(state), S_RUN);
    chk("fr_post_ctl", 32'(ctl), 32'(C_RUN));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
